irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 16, number of interrupt sources (legal range 1..32).
REQ-002 SHALL have parameter EDGE_MASK, default all ones (NUM_SRC bits), bit n=1 makes source n rising-edge sensitive, 0 makes it level sensitive.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port src_i  input  NUM_SRC  raw interrupt sources, asynchronous to clk_i.
REQ-006 SHALL have port en_we_i  input  1  write strobe for the enable mask.
REQ-007 SHALL have port en_wdata_i  input  NUM_SRC  new enable mask.
REQ-008 SHALL have port meip_o  output  1  machine external interrupt request to the core.
REQ-009 SHALL have port irq_ack_i  input  1  one-cycle acknowledge pulse from the core.
REQ-010 SHALL have port claim_id_o  output  5  index of the source being signalled.
REQ-011 SHALL have port pending_o  output  NUM_SRC  current pending vector.

Function
REQ-012 Each src_i bit SHALL pass through a two-flop synchronizer, then a one-flop delay for edge detection.
REQ-013 Edge source: pending bit SHALL set on the edge where synchronized value is 1 and delayed value is 0; SHALL clear only by acknowledge.
REQ-014 Level source: pending bit SHALL equal the synchronized value every cycle; acknowledge SHALL NOT clear it.
REQ-015 Enable mask SHALL load en_wdata_i on the edge where en_we_i=1; masked sources still record pending but never request.
REQ-016 FSM states: IDLE, REQ, HOLD.
REQ-017 IDLE->REQ when (pending & enable) != 0; claim_id_o SHALL latch the selected index on that edge.
REQ-018 Selection (default): lowest-index bit of pending & enable wins.
REQ-019 REQ->HOLD on edge where irq_ack_i=1; the claimed edge pending bit SHALL clear on that edge.
REQ-020 HOLD->IDLE unconditionally after one cycle, guaranteeing meip_o low for at least one cycle between requests.
REQ-021 meip_o SHALL be registered and equal (state==REQ); claim_id_o holds its value in REQ and HOLD.
REQ-022 Latency: enabled edge source rising with setup met, FSM in IDLE, meip_o SHALL go high after the 4th rising clk_i edge.
REQ-023 New edge on the claimed bit in the same cycle as its acknowledge: set SHALL win (bit stays pending).
REQ-024 Enable of claimed source cleared while in REQ: request SHALL remain until acknowledged.
REQ-025 irq_ack_i in IDLE or HOLD SHALL be ignored.
REQ-026 Unused claim_id_o upper bits SHALL be 0.

Reset
REQ-027 reset_i high SHALL immediately clear synchronizers, delay flops, pending, enable mask, claim_id_o, meip_o, and force IDLE.
REQ-028 Reset asserted mid-request SHALL drop meip_o without waiting for acknowledge; no pending state survives.

Configuration
REQ-029 Macro IRQ_CTRL_RR_EN defined: selection SHALL be round-robin, search starting at (last acknowledged index + 1) mod NUM_SRC; last index resets to NUM_SRC-1.
REQ-030 Macro IRQ_CTRL_RR_EN undefined: fixed lowest-index priority per REQ-018; no round-robin state is built.

Verification
REQ-031 NUM_SRC=16, enable=0x0001, pulse src_i[0] -> meip_o high on 4th edge, claim_id_o=0; ack -> meip_o low next edge, pending_o=0.
REQ-032 enable=0xFFFF, src_i[3] and src_i[9] rise together -> claim 3, ack, HOLD, then claim 9 (RR off); RR on after prior ack of 5 -> claim 9 first, then 3.
REQ-033 Level source 2 (EDGE_MASK bit 2=0) held high, ack -> meip_o reasserts after HOLD with claim 2; drop src_i[2] -> pending_o[2]=0 three edges later, no further request.
REQ-034 enable=0, pulse src_i[5] -> pending_o[5]=1, meip_o stays 0; write enable=0x0020 -> meip_o high next edge+1, claim 5.
REQ-035 Assert reset_i while meip_o=1 -> meip_o, pending_o, claim_id_o all 0 before next clock edge; release -> stays IDLE with no source activity.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: core-side bus of irq_ctrl: enable-mask write, request/claim/acknowledge, pending view.
// The controller takes the slave modport, the core (or bench) the master modport.
interface irq_ctrl_if #(parameter int NUM_SRC = 16);
   logic               en_we_i;
   logic [NUM_SRC-1:0] en_wdata_i;
   logic               irq_ack_i;
   logic               meip_o;
   logic [4:0]         claim_id_o;
   logic [NUM_SRC-1:0] pending_o;
   modport slave (input en_we_i, en_wdata_i, irq_ack_i, output meip_o, claim_id_o, pending_o);
   modport master (output en_we_i, en_wdata_i, irq_ack_i, input meip_o, claim_id_o, pending_o);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronised edge/level interrupt sources, enable mask, IDLE/REQ/HOLD request FSM.
// Define IRQ_CTRL_RR_EN for round-robin selection; default is fixed lowest-index priority.
module irq_ctrl #(
   parameter int                 NUM_SRC   = 16,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = '1
) (
   input logic               clk_i,
   input logic               reset_i,
   input logic [NUM_SRC-1:0] src_i,
   irq_ctrl_if.slave         bus
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2;
   localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);
   logic [NUM_SRC-1:0] s1_q, s2_q, dly_q, pend_q, pend_d, en_q, req, rise, clr, scan;
   logic [1:0]         state_q, state_d;
   logic [4:0]         claim_q, claim_d, sel;
   logic               meip_q, ack;
   int                 base, j;
   always_comb begin
      req     = pend_q & en_q;
      rise    = s2_q & ~dly_q;
      ack     = state_q == REQ && bus.irq_ack_i;
      clr     = ack ? ONE << claim_q : '0;
      // a fresh edge on the claimed bit beats its acknowledge
      pend_d  = (EDGE_MASK & ((pend_q & ~clr) | rise)) | (~EDGE_MASK & s2_q);
      state_d = state_q == HOLD ? IDLE : state_q == REQ ? (ack ? HOLD : REQ) : (|req ? REQ : IDLE);
      claim_d = (state_q == IDLE && |req) ? sel : claim_q;
   end
`ifdef IRQ_CTRL_RR_EN
   logic [4:0] last_q;
   // rotate so the search starts just after the last acknowledged source
   assign base = int'(last_q) + 1;
   assign scan = NUM_SRC'({req, req} >> base);
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) last_q <= 5'(NUM_SRC - 1);
      else if (ack) last_q <= claim_q;
`else
   assign base = 0;
   assign scan = req;
`endif
   always_comb begin
      j = 0;
      for (int i = NUM_SRC - 1; i >= 0; i--) if (scan[i]) j = i;
      sel = 5'((base + j) % NUM_SRC);
   end
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         s1_q    <= '0;
         s2_q    <= '0;
         dly_q   <= '0;
         pend_q  <= '0;
         en_q    <= '0;
         state_q <= IDLE;
         claim_q <= '0;
         meip_q  <= 1'b0;
      end else begin
         s1_q    <= src_i;
         s2_q    <= s1_q;
         dly_q   <= s2_q;
         pend_q  <= pend_d;
         if (bus.en_we_i) en_q <= bus.en_wdata_i;
         state_q <= state_d;
         claim_q <= claim_d;
         meip_q  <= state_d == REQ;
      end
   assign bus.meip_o     = meip_q;
   assign bus.claim_id_o = claim_q;
   assign bus.pending_o  = pend_q;
endmodule
